sprite_plotter: RTL and testbench
=================================

# sprite_plotter

Pixel-drawing engine that answers the game control FSM's one-hot `draw_*_s` strobes with a single-cycle `plot_done`. On each accepted request it scans the selected sprite's rectangle row by row and reads the shared sprite ROM. It streams pixel writes (`x`, `y`, `colour`, `plot`) into the VGA adapter, sitting between the control FSM and the VGA adapter.

## Interface
- `SCREEN_W`, default 160: visible width in pixels.
- `SCREEN_H`, default 120: visible height in pixels.
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `COLOUR_W`, default 3: pixel colour width.
- `ADDR_W`, default 16: sprite ROM address width.
- `NUM_SPR`, default 14: number of drawable sprites, which is also the width of `draw_s`.
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-low reset.
- `draw_s`, in, `NUM_SPR`: one-hot draw request, held high by the control FSM for as long as it sits in a DRAW state. Bit order is fixed by the package.
- `rom_addr`, out, `ADDR_W`: sprite ROM address (registered).
- `rom_data`, in, `COLOUR_W`: ROM read data, valid exactly one cycle after `rom_addr`.
- `vga_x`, out, `X_W`: pixel x coordinate.
- `vga_y`, out, `Y_W`: pixel y coordinate.
- `vga_colour`, out, `COLOUR_W`: pixel colour.
- `vga_plot`, out, 1: write-enable for the current pixel.
- `plot_done`, out, 1: one-cycle pulse when the requested sprite is finished.
- `busy`, out, 1: high from acceptance until `plot_done`.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE, HOLD.
- IDLE:
  - A request is pending when `draw_s` is non-zero. If several bits are high, the lowest index wins.
  - On a request, latch the sprite's table entry: origin `ox`/`oy`, width `w`, height `h`, ROM `base`, and `keyed` flag. Clear `cx`, `cy` and `offset`, then go to RUN.
- RUN:
  - Each cycle drives `rom_addr = base + offset` and forwards (`ox+cx`, `oy+cy`, `valid=1`) into pipeline stage 1.
  - `offset` increments by 1 every cycle. Sprite data is row-major and contiguous, so no multiplier is needed.
  - `cx` wraps from `w-1` to 0, and `cy` increments on that wrap.
  - After the pixel (`w-1`, `h-1`), go to FLUSH.
- FLUSH: two cycles with no new addresses, draining stage 1 and stage 2. Then go to DONE.
- DONE: `plot_done=1` for this one cycle, then go to HOLD.
- HOLD: stay while `draw_s` remains non-zero; return to IDLE when `draw_s` is 0. A strobe still held after completion never triggers a redraw.
- Stage 2, the output register, loads every cycle:
  - `vga_x`, `vga_y` and `vga_colour` take the stage-1 coordinates and `rom_data`.
  - `vga_plot = valid && !(keyed && rom_data == KEY_COLOUR) && x < SCREEN_W && y < SCREEN_H`.
  - Clipped or transparent pixels still use their cycle.
- Keying: background, start and dead screens are unkeyed (opaque). All item and bubble sprites are keyed.
- Width rules:
  - Screen coordinate sums are computed one bit wider, so clipping catches overflow.
  - `offset` is `ADDR_W` bits. Base plus size never exceeds the ROM; the package guarantees this and the plotter does not check it.
- Reset (`reset==0` at a clock edge), including mid-scan:
  - State returns to IDLE. All outputs go to 0: `rom_addr`, `vga_x`, `vga_y`, `vga_colour`, `vga_plot`, `plot_done`, `busy`.
  - The pipeline's valid bits are cleared, and no `plot_done` is issued for an aborted draw.
- `draw_s` changing during RUN/FLUSH is ignored. The latched sprite always completes.

## Timing
- Cycle 0 is the first edge with IDLE and a request. RUN occupies cycles 1..N, where N = w·h, with the first `rom_addr` valid in cycle 1.
- First `vga_plot` opportunity: cycle 3. Last pixel on the VGA outputs: cycle N+2.
- `plot_done` is high in cycle N+3, and `busy` is high during cycles 1..N+2.
- Throughput: one pixel per clock.
- Minimum request-to-request spacing: N+5 cycles, because HOLD needs at least one cycle with `draw_s==0`.

## Structure
- Package `plotter_pkg`:
  - Sprite index localparams: `SPR_START=0`, `SPR_BG`, `SPR_FOOD`, `SPR_PILLS`, `SPR_FIRST_AID`, `SPR_BALL`, `SPR_BROOM`, `SPR_HUNGER`, `SPR_BORED`, `SPR_SICK`, `SPR_DIRTY`, `SPR_DYING`, `SPR_ZZZS`, `SPR_DEAD`.
  - The per-sprite table of (`ox`, `oy`, `w`, `h`, `base`, `keyed`).
  - `KEY_COLOUR=3'b000`.
- One sub-module, `sprite_scan_counter`: owns `cx`, `cy` and `offset`, with the `last` flag and row wrap. The top level holds the FSM, the priority select, the pipeline and the clip/key logic.

## Test plan
- Background: `draw_s` bit `SPR_BG` held high, table entry 160×120 at (0,0).
  - Exactly 19200 cycles with `vga_plot=1`, covering (0,0)..(159,119) in row-major order.
  - `plot_done` pulses in cycle 19203, and `busy` falls in the same cycle.
- Small keyed sprite: 4×2 at (10,20), ROM data 1,0,2,3,0,4,5,6.
  - `vga_plot` is high only for (10,20),(12,20),(13,20),(11,21),(12,21),(13,21), with matching colours, across cycles 3..10.
  - `plot_done` pulses in cycle 11.
- Priority and hold: `draw_s=14'b00000000000110` held for 200 cycles.
  - Only `SPR_BG` is drawn, with one `plot_done`.
  - After `draw_s` drops for one cycle and is re-raised, the draw restarts.
- Clipping: an 8×8 sprite at (156,116).
  - Only the 4×4 on-screen pixels plot.
  - `plot_done` still pulses at cycle 67.
- Reset mid-scan: assert `reset=0` during cycle 50 of a background draw.
  - The next cycle shows all outputs 0 and state IDLE, with no `plot_done`.
  - A fresh request after release completes normally.
- Request change during RUN: switch `draw_s` from `SPR_FOOD` to `SPR_BALL` mid-scan.
  - Food completes unaltered and `plot_done` fires once.
  - Ball is not drawn until `draw_s` returns to 0 and then rises again.

Source files
------------

// File: rtl/plotter_pkg.sv
// rtl/plotter_pkg.sv - sprite indices, sprite table and shared types for the sprite plotter
package plotter_pkg;

   localparam int SPR_COUNT = 14;

   localparam logic [3:0] SPR_START     = 4'd0;
   localparam logic [3:0] SPR_BG        = 4'd1;
   localparam logic [3:0] SPR_FOOD      = 4'd2;
   localparam logic [3:0] SPR_PILLS     = 4'd3;
   localparam logic [3:0] SPR_FIRST_AID = 4'd4;
   localparam logic [3:0] SPR_BALL      = 4'd5;
   localparam logic [3:0] SPR_BROOM     = 4'd6;
   localparam logic [3:0] SPR_HUNGER    = 4'd7;
   localparam logic [3:0] SPR_BORED     = 4'd8;
   localparam logic [3:0] SPR_SICK      = 4'd9;
   localparam logic [3:0] SPR_DIRTY     = 4'd10;
   localparam logic [3:0] SPR_DYING     = 4'd11;
   localparam logic [3:0] SPR_ZZZS      = 4'd12;
   localparam logic [3:0] SPR_DEAD      = 4'd13;

   localparam logic [2:0] KEY_COLOUR = 3'b000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE,
      ST_HOLD
   } plot_state_t;

   typedef struct packed {
      logic [7:0]  ox;
      logic [6:0]  oy;
      logic [7:0]  w;
      logic [6:0]  h;
      logic [15:0] base;
      logic        keyed;
   } spr_entry_t;

   // Bases are packed back to back; full-screen images are opaque, everything else is keyed.
   function automatic spr_entry_t spr_lookup(input logic [3:0] idx);
      spr_entry_t e;
      case (idx)
         SPR_START:     e = '{8'd0,   7'd0,   8'd160, 7'd120, 16'd0,     1'b0};
         SPR_BG:        e = '{8'd0,   7'd0,   8'd160, 7'd120, 16'd19200, 1'b0};
         SPR_FOOD:      e = '{8'd10,  7'd20,  8'd4,   7'd2,   16'd38400, 1'b1};
         SPR_PILLS:     e = '{8'd156, 7'd116, 8'd8,   7'd8,   16'd38408, 1'b1};
         SPR_FIRST_AID: e = '{8'd30,  7'd40,  8'd6,   7'd5,   16'd38472, 1'b1};
         SPR_BALL:      e = '{8'd50,  7'd60,  8'd5,   7'd5,   16'd38502, 1'b1};
         SPR_BROOM:     e = '{8'd70,  7'd10,  8'd7,   7'd3,   16'd38527, 1'b1};
         SPR_HUNGER:    e = '{8'd100, 7'd5,   8'd8,   7'd4,   16'd38548, 1'b1};
         SPR_BORED:     e = '{8'd110, 7'd5,   8'd8,   7'd4,   16'd38580, 1'b1};
         SPR_SICK:      e = '{8'd120, 7'd5,   8'd8,   7'd4,   16'd38612, 1'b1};
         SPR_DIRTY:     e = '{8'd130, 7'd5,   8'd8,   7'd4,   16'd38644, 1'b1};
         SPR_DYING:     e = '{8'd140, 7'd5,   8'd8,   7'd4,   16'd38676, 1'b1};
         SPR_ZZZS:      e = '{8'd150, 7'd100, 8'd12,  7'd10,  16'd38708, 1'b1};
         SPR_DEAD:      e = '{8'd0,   7'd0,   8'd160, 7'd120, 16'd38828, 1'b0};
         default:       e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// rtl/sprite_scan_counter.sv - row-major scan position and linear ROM offset for one sprite
module sprite_scan_counter #(
   parameter int X_W    = 8,
   parameter int Y_W    = 7,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              advance,
   input  logic [X_W-1:0]    w,
   input  logic [Y_W-1:0]    h,
   output logic [X_W-1:0]    cx,
   output logic [Y_W-1:0]    cy,
   output logic [ADDR_W-1:0] offset,
   output logic              last
);

   logic row_end;

   assign row_end = (cx == w - X_W'(1));
   assign last    = row_end && (cy == h - Y_W'(1));

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         cx     <= '0;
         cy     <= '0;
         offset <= '0;
      end else if (advance) begin
         offset <= offset + ADDR_W'(1);
         cx     <= row_end ? '0 : cx + X_W'(1);
         cy     <= row_end ? cy + Y_W'(1) : cy;
      end
   end

endmodule

// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - draws the requested sprite into the VGA adapter, one pixel per clock
module sprite_plotter
   import plotter_pkg::*;
#(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COLOUR_W = 3,
   parameter int ADDR_W   = 16,
   parameter int NUM_SPR  = SPR_COUNT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_SPR-1:0]  draw_s,
   output logic [ADDR_W-1:0]   rom_addr,
   input  logic [COLOUR_W-1:0] rom_data,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot,
   output logic                plot_done,
   output logic                busy
);

   localparam logic [X_W:0] X_LIM = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(SCREEN_H);

   plot_state_t state, state_next;
   logic        flush_second, req, accept, advance, last;
   logic [3:0]  sel_idx;
   spr_entry_t  sel_entry;

   logic [X_W-1:0]    ox_q, w_q, cx;
   logic [Y_W-1:0]    oy_q, h_q, cy;
   logic [ADDR_W-1:0] base_q, offset;
   logic              keyed_q;
   logic              s1_valid;
   logic [X_W:0]      s1_x;
   logic [Y_W:0]      s1_y;

   assign req = |draw_s;

   always_comb begin
      sel_idx = '0;
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         if (draw_s[i]) sel_idx = 4'(i);
      end
   end

   assign sel_entry = spr_lookup(sel_idx);

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (req) state_next = ST_RUN;
         ST_RUN:   if (last) state_next = ST_FLUSH;
         ST_FLUSH: if (flush_second) state_next = ST_DONE;
         ST_DONE:  state_next = ST_HOLD;
         ST_HOLD:  if (!req) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      accept    = 1'b0;
      advance   = 1'b0;
      busy      = 1'b0;
      plot_done = 1'b0;
      case (state)
         ST_IDLE:  accept    = req;
         ST_RUN:   begin advance = 1'b1; busy = 1'b1; end
         ST_FLUSH: busy      = 1'b1;
         ST_DONE:  plot_done = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) flush_second <= 1'b0;
      else        flush_second <= (state == ST_FLUSH) && !flush_second;
   end

   sprite_scan_counter #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_scan (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .advance (advance),
      .w       (w_q),
      .h       (h_q),
      .cx      (cx),
      .cy      (cy),
      .offset  (offset),
      .last    (last)
   );

   // rom_addr runs one pixel ahead of stage 1 so rom_data lines up with stage 1 a cycle later.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rom_addr   <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         w_q        <= '0;
         h_q        <= '0;
         base_q     <= '0;
         keyed_q    <= 1'b0;
         s1_valid   <= 1'b0;
         s1_x       <= '0;
         s1_y       <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         if (accept) begin
            ox_q     <= sel_entry.ox;
            oy_q     <= sel_entry.oy;
            w_q      <= sel_entry.w;
            h_q      <= sel_entry.h;
            base_q   <= sel_entry.base;
            keyed_q  <= sel_entry.keyed;
            rom_addr <= sel_entry.base;
         end else if (advance) begin
            rom_addr <= base_q + offset + ADDR_W'(1);
         end
         s1_valid   <= advance;
         s1_x       <= {1'b0, ox_q} + {1'b0, cx};
         s1_y       <= {1'b0, oy_q} + {1'b0, cy};
         vga_x      <= s1_x[X_W-1:0];
         vga_y      <= s1_y[Y_W-1:0];
         vga_colour <= rom_data;
         vga_plot   <= s1_valid && !(keyed_q && rom_data == KEY_COLOUR)
                       && (s1_x < X_LIM) && (s1_y < Y_LIM);
      end
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - randomized self-checking bench for sprite_plotter against a pixel-list model
module tb_sprite_plotter;

   localparam int I_BG    = 1;
   localparam int I_FOOD  = 2;
   localparam int I_PILLS = 3;
   localparam int I_BALL  = 5;

   typedef struct packed {
      int ox;
      int oy;
      int w;
      int h;
      int base;
      bit keyed;
   } spr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [13:0] draw_s = '0;
   logic [15:0] rom_addr;
   logic [2:0]  rom_data = '0;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        plot_done;
   logic        busy;

   logic [2:0] rom_mem [0:65535];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   sprite_plotter dut (
      .clk        (clk),
      .reset      (reset),
      .draw_s     (draw_s),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .plot_done  (plot_done),
      .busy       (busy)
   );

   function automatic spr_t spr(input int idx);
      spr_t e;
      case (idx)
         I_BG:    e = '{ox:0,   oy:0,   w:160, h:120, base:19200, keyed:1'b0};
         I_FOOD:  e = '{ox:10,  oy:20,  w:4,   h:2,   base:38400, keyed:1'b1};
         I_PILLS: e = '{ox:156, oy:116, w:8,   h:8,   base:38408, keyed:1'b1};
         I_BALL:  e = '{ox:50,  oy:60,  w:5,   h:5,   base:38502, keyed:1'b1};
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sprite pixel p is expected on the VGA outputs in cycle p+3; done in cycle N+3.
   task automatic run_draw(input string name, input logic [13:0] req, input int idx,
                           input int sw_cycle, input logic [13:0] sw_req, input int extra);
      spr_t  e;
      int    n, exp_plots, got_plots, pix_bad, busy_bad, done_cnt, done_at;
      string first_bad;
      e = spr(idx);
      n = e.w * e.h;
      exp_plots = 0; got_plots = 0; pix_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
      first_bad = "";
      draw_s = req;
      for (int s = 1; s <= n + 3 + extra; s++) begin
         int p, ex, ey;
         bit ep;
         logic [2:0] ec;
         tick();
         p = s - 3; ep = 1'b0; ex = 0; ey = 0; ec = '0;
         if (p >= 0 && p < n) begin
            ex = e.ox + p % e.w;
            ey = e.oy + p / e.w;
            ec = rom_mem[e.base + p];
            ep = !(e.keyed && ec == 3'd0) && ex < 160 && ey < 120;
         end
         if (ep) exp_plots++;
         if (vga_plot === 1'b1) got_plots++;
         if (vga_plot !== ep || (ep && (vga_x !== ex[7:0] || vga_y !== ey[6:0] || vga_colour !== ec))) begin
            if (pix_bad == 0)
               first_bad = $sformatf("cycle %0d got plot=%0b (%0d,%0d,%0d) want plot=%0b (%0d,%0d,%0d)",
                                     s, vga_plot, vga_x, vga_y, vga_colour, ep, ex, ey, ec);
            pix_bad++;
         end
         if (busy !== (s <= n + 2)) busy_bad++;
         if (plot_done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = s;
         end
         if (s == sw_cycle) draw_s = sw_req;
      end
      checks++;
      if (got_plots !== exp_plots) begin
         errors++;
         $display("FAIL %s plot_count got %0d want %0d", name, got_plots, exp_plots);
      end
      checks++;
      if (pix_bad !== 0) begin
         errors++;
         $display("FAIL %s pixels got %0d bad cycles want 0, first: %s", name, pix_bad, first_bad);
      end
      checks++;
      if (done_at !== n + 3) begin
         errors++;
         $display("FAIL %s done_cycle got %0d want %0d", name, done_at, n + 3);
      end
      checks++;
      if (done_cnt !== 1) begin
         errors++;
         $display("FAIL %s done_count got %0d want 1", name, done_cnt);
      end
      checks++;
      if (busy_bad !== 0) begin
         errors++;
         $display("FAIL %s busy got %0d wrong cycles want 0", name, busy_bad);
      end
   endtask

   task automatic drop_request();
      draw_s = '0;
      tick();
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (rom_addr !== 16'd0) begin errors++; $display("FAIL %s rom_addr got %0d want 0", name, rom_addr); end
      checks++;
      if (vga_x !== 8'd0) begin errors++; $display("FAIL %s vga_x got %0d want 0", name, vga_x); end
      checks++;
      if (vga_y !== 7'd0) begin errors++; $display("FAIL %s vga_y got %0d want 0", name, vga_y); end
      checks++;
      if (vga_colour !== 3'd0) begin errors++; $display("FAIL %s vga_colour got %0d want 0", name, vga_colour); end
      checks++;
      if (vga_plot !== 1'b0) begin errors++; $display("FAIL %s vga_plot got %0b want 0", name, vga_plot); end
      checks++;
      if (plot_done !== 1'b0) begin errors++; $display("FAIL %s plot_done got %0b want 0", name, plot_done); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL %s busy got %0b want 0", name, busy); end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      draw_s = 14'($urandom_range(1, 16383));
      repeat (3) tick();
      check_outputs_zero("reset");
      draw_s = '0;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_background();
      run_draw("background", 14'(1) << I_BG, I_BG, 0, '0, 4);
      drop_request();
   endtask

   task automatic test_priority_hold();
      run_draw("priority_hold", 14'b00000000000110, I_BG, 0, '0, 200);
   endtask

   task automatic test_reset_mid_scan();
      int done_seen;
      drop_request();
      draw_s = 14'b00000000000110;
      for (int s = 1; s <= 49; s++) begin
         tick();
         if (s == 1) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL restart busy got %0b want 1", busy); end
            checks++;
            if (rom_addr !== 16'd19200) begin errors++; $display("FAIL restart rom_addr got %0d want 19200", rom_addr); end
         end
      end
      reset = 1'b0;
      tick();
      check_outputs_zero("reset_mid_scan");
      draw_s = '0;
      tick();
      reset = 1'b1;
      done_seen = 0;
      repeat (10) begin
         tick();
         if (plot_done === 1'b1 || busy === 1'b1) done_seen++;
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL reset_abort got %0d cycles of done/busy want 0", done_seen);
      end
      run_draw("after_reset", 14'(1) << I_FOOD, I_FOOD, 0, '0, 4);
      drop_request();
   endtask

   task automatic test_keyed_small();
      run_draw("keyed_small", 14'(1) << I_FOOD, I_FOOD, 0, '0, 4);
      drop_request();
   endtask

   task automatic test_clipping();
      run_draw("clipping", 14'(1) << I_PILLS, I_PILLS, 0, '0, 4);
      drop_request();
   endtask

   task automatic test_request_change();
      run_draw("req_change", 14'(1) << I_FOOD, I_FOOD, 4, 14'(1) << I_BALL, 20);
      drop_request();
      run_draw("ball_after_drop", 14'(1) << I_BALL, I_BALL, 0, '0, 4);
      drop_request();
   endtask

   // Lower-index request bit must win over random higher-index noise.
   task automatic test_random_priority();
      int picks [3] = '{I_FOOD, I_PILLS, I_BALL};
      for (int k = 0; k < 4; k++) begin
         int idx;
         logic [13:0] noise;
         idx = picks[$urandom_range(0, 2)];
         noise = 14'($urandom) << (idx + 1);
         for (int a = 38502; a < 38527; a++) rom_mem[a] = 3'($urandom_range(0, 7));
         run_draw($sformatf("random_%0d", k), noise | (14'(1) << idx), idx, 0, '0, 3);
         drop_request();
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) rom_mem[a] = 3'($urandom_range(0, 7));
      rom_mem[38400] = 3'd1; rom_mem[38401] = 3'd0; rom_mem[38402] = 3'd2; rom_mem[38403] = 3'd3;
      rom_mem[38404] = 3'd0; rom_mem[38405] = 3'd4; rom_mem[38406] = 3'd5; rom_mem[38407] = 3'd6;
      for (int a = 38408; a < 38472; a++) rom_mem[a] = 3'($urandom_range(1, 7));

      test_reset();
      test_background();
      test_priority_hold();
      test_reset_mid_scan();
      test_keyed_small();
      test_clipping();
      test_request_change();
      test_random_priority();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
